// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter.
// Contents:
//   PAR_NONE / PAR_ODD / PAR_EVEN : parity mode encodings for the PARITY parameter
//   xmt_state_e                   : transmitter FSM state
//   cnt_width / lvl_width         : width helpers for bit timer and FIFO level
//   parity_bit                    : parity of a zero-extended character
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } xmt_state_e;

  // Bits needed for a down-counter holding n-1 .. 0.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Bits needed for an occupancy count 0 .. depth.
  function automatic int lvl_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Parity bit for a character; unused upper bits must already be zero.
  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    logic x;
    x = ^data;
    if (mode == PAR_ODD) begin
      return ~x;
    end else begin
      return x;
    end
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO buffering characters ahead of the transmitter.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   push_i      : write wdata_i (ignored while full_o)
//   wdata_i     : character to store
//   pop_i       : remove head entry (ignored while empty)
//   rdata_o     : current head entry
//   full_o      : level_o == DEPTH
//   level_o     : number of stored entries
//   overflow_o  : one-cycle pulse after a push that was refused because full
module uart_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push_i,
  input  logic [WIDTH-1:0]            wdata_i,
  input  logic                        pop_i,
  output logic [WIDTH-1:0]            rdata_o,
  output logic                        full_o,
  output logic [lvl_width(DEPTH)-1:0] level_o,
  output logic                        overflow_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = lvl_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic [LW-1:0]    level_d;
  logic             overflow_q;
  logic             wr_en_s;
  logic             rd_en_s;

  // full is judged on the registered level, so a same-cycle pop never frees room for a push.
  assign full_o     = (level_q == LW'(DEPTH));
  assign wr_en_s    = push_i & ~full_o;
  assign rd_en_s    = pop_i & (level_q != LW'(0));
  assign rdata_o    = mem_q[rd_ptr_q];
  assign level_o    = level_q;
  assign overflow_o = overflow_q;

  // Next occupancy: simultaneous push and pop leave it unchanged.
  always_comb begin
    level_d = level_q;
    if (wr_en_s && !rd_en_s) begin
      level_d = level_q + LW'(1);
    end else if (rd_en_s && !wr_en_s) begin
      level_d = level_q - LW'(1);
    end else begin
      level_d = level_q;
    end
  end

  // Pointers, level and overflow flag; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= PW'(0);
      rd_ptr_q   <= PW'(0);
      level_q    <= LW'(0);
      overflow_q <= 1'b0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (rd_en_s) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      level_q    <= level_d;
      overflow_q <= push_i & full_o;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/uart_xmt_fifo.sv
// Parametrised serial transmitter with an input FIFO.
// Ports:
//   clk, reset   : clock, asynchronous active-low reset
//   load         : queue parallel_in (ignored while full)
//   parallel_in  : character; bits above DATA_BITS-1 are dropped
//   full         : FIFO full
//   empty        : FIFO empty and line idle
//   level        : FIFO occupancy (frame in the shifter not counted)
//   overflow     : one-cycle pulse after a refused load
//   serial_out   : TX line, idle high
// Frame: start(0), DATA_BITS data LSB first, optional parity, STOP_BITS stop(1),
// each bit BIT_CYCLES clocks. A queued character starts right after the last stop bit.
module uart_xmt_fifo
  import uart_pkg::*;
#(
  parameter int BIT_CYCLES = 1303,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             load,
  input  logic [7:0]                       parallel_in,
  output logic                             full,
  output logic                             empty,
  output logic [lvl_width(FIFO_DEPTH)-1:0] level,
  output logic                             overflow,
  output logic                             serial_out
);

  localparam int               CW        = cnt_width(BIT_CYCLES);
  localparam int               LW        = lvl_width(FIFO_DEPTH);
  localparam logic [CW-1:0]    BIT_LAST  = CW'(BIT_CYCLES - 1);
  localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

  if (BIT_CYCLES < 2 || DATA_BITS < 5 || DATA_BITS > 8 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("uart_xmt_fifo: illegal parameter combination");
  end

  xmt_state_e           state_q;
  xmt_state_e           state_d;
  logic [CW-1:0]        cnt_q;
  logic [CW-1:0]        cnt_d;
  logic [2:0]           idx_q;
  logic [2:0]           idx_d;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_d;
  logic                 par_q;
  logic                 par_d;
  logic                 serial_q;
  logic                 serial_d;
  logic                 pop_s;
  logic                 bit_done_s;
  logic                 avail_s;
  logic [DATA_BITS-1:0] head_s;
  logic                 unused_s;

  // Upper character bits are intentionally discarded when DATA_BITS < 8.
  assign unused_s = ^parallel_in;

  uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (reset),
    .push_i     (load),
    .wdata_i    (parallel_in[DATA_BITS-1:0]),
    .pop_i      (pop_s),
    .rdata_o    (head_s),
    .full_o     (full),
    .level_o    (level),
    .overflow_o (overflow)
  );

  assign avail_s    = (level != LW'(0));
  assign bit_done_s = (cnt_q == CW'(0));
  assign serial_out = serial_q;
  assign empty      = (level == LW'(0)) && (state_q == ST_IDLE);

  // Next-state logic: bit timer, bit index, shifter and FIFO pop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    pop_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (avail_s) begin
          pop_s   = 1'b1;
          state_d = ST_START;
          cnt_d   = BIT_LAST;
          idx_d   = 3'd0;
          shift_d = head_s;
          par_d   = parity_bit(8'(head_s), PARITY);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_done_s) begin
          state_d = ST_DATA;
          cnt_d   = BIT_LAST;
          idx_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DATA: begin
        if (bit_done_s) begin
          cnt_d = BIT_LAST;
          if (idx_q == DATA_LAST) begin
            idx_d = 3'd0;
            if (PARITY != PAR_NONE) begin
              state_d = ST_PAR;
            end else begin
              state_d = ST_STOP;
            end
          end else begin
            idx_d   = idx_q + 3'd1;
            shift_d = shift_q >> 1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_PAR: begin
        if (bit_done_s) begin
          state_d = ST_STOP;
          cnt_d   = BIT_LAST;
          idx_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_STOP: begin
        if (bit_done_s) begin
          if (idx_q != STOP_LAST) begin
            idx_d = idx_q + 3'd1;
            cnt_d = BIT_LAST;
          end else if (avail_s) begin
            // Chain straight into the next start bit with no idle gap.
            pop_s   = 1'b1;
            state_d = ST_START;
            cnt_d   = BIT_LAST;
            idx_d   = 3'd0;
            shift_d = head_s;
            par_d   = parity_bit(8'(head_s), PARITY);
          end else begin
            state_d = ST_IDLE;
            cnt_d   = CW'(0);
            idx_d   = 3'd0;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CW'(0);
        idx_d   = 3'd0;
      end
    endcase
  end

  // Line level for the state being entered, so serial_out is a plain register.
  always_comb begin
    serial_d = 1'b1;
    case (state_d)
      ST_START: serial_d = 1'b0;
      ST_DATA:  serial_d = shift_d[0];
      ST_PAR:   serial_d = par_d;
      default:  serial_d = 1'b1;
    endcase
  end

  // FSM and datapath registers; reset forces the line high immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= CW'(0);
      idx_q    <= 3'd0;
      shift_q  <= {DATA_BITS{1'b0}};
      par_q    <= 1'b0;
      serial_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      serial_q <= serial_d;
    end
  end

endmodule
